// File: rtl/ecap5_dwbuart_fifo.sv
// Wishbone register and buffering core for the UART: RX/TX FIFOs, TX dispatch FSM,
// sticky error flags, RX level threshold and a registered level interrupt.
//
// TX FSM states:
//   state   | meaning
//   TX_IDLE | no frame in flight; pops the next byte as soon as the TX FIFO holds one
//   TX_BUSY | tx_frontend is sending tx_data_o; waits for tx_done_i
module ecap5_dwbuart_fifo #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  input  logic [7:0]  rx_frame_i,
  input  logic        rx_valid_i,
  input  logic        rx_parity_err_i,
  input  logic        rx_frame_err_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_transmit_o,
  input  logic        tx_done_i,
  output logic [15:0] cr_acc_incr_o,
  output logic        cr_ds_o,
  output logic        cr_s_o,
  output logic [1:0]  cr_p_o,
  output logic        frontend_rst_o,
  output logic        irq_o
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_LW = RX_AW + 1;
  localparam int TX_LW = TX_AW + 1;
  localparam logic [RX_LW-1:0] RX_FULL    = RX_LW'(RX_DEPTH);
  localparam logic [TX_LW-1:0] TX_FULL    = TX_LW'(TX_DEPTH);
  localparam logic [7:0]       RX_DEPTH_B = 8'(RX_DEPTH);

  localparam logic [5:0] A_SR   = 6'd0;
  localparam logic [5:0] A_CR   = 6'd1;
  localparam logic [5:0] A_RXDR = 6'd2;
  localparam logic [5:0] A_TXDR = 6'd3;
  localparam logic [5:0] A_IER  = 6'd4;
  localparam logic [5:0] A_FCR  = 6'd5;

  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  logic        req, wr, rd;
  logic [5:0]  idx;
  logic        cr_wr, txdr_wr, ier_wr, fcr_wr, sr_rd, rxdr_rd;
  logic        rx_flush, tx_flush;
  logic [31:0] rdata;
  logic [2:0]  ier;
  logic [7:0]  rx_thresh, th_sat;
  logic        rxoe, fe, pe, txoe;
  logic        unused_bits;

  assign req = wb_stb_i & wb_cyc_i;
  assign wr  = req & wb_we_i;
  assign rd  = req & ~wb_we_i;
  assign idx = wb_adr_i[7:2];

  assign cr_wr   = wr && (idx == A_CR);
  assign txdr_wr = wr && (idx == A_TXDR);
  assign ier_wr  = wr && (idx == A_IER);
  assign fcr_wr  = wr && (idx == A_FCR);
  assign sr_rd   = rd && (idx == A_SR);
  assign rxdr_rd = rd && (idx == A_RXDR);

  // A CR write reconfigures the frontends, so any buffered data is stale.
  assign rx_flush = cr_wr | (fcr_wr & wb_dat_i[0]);
  assign tx_flush = cr_wr | (fcr_wr & wb_dat_i[1]);

  assign wb_stall_o  = 1'b0;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0]};

  // RX FIFO
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_rd_ptr, rx_wr_ptr;
  logic [RX_LW-1:0] rx_level;
  logic [7:0]       rx_level8;
  logic             rx_empty, rx_full, rx_pop, rx_push, rx_ovr, rxth;

  assign rx_empty  = (rx_level == '0);
  assign rx_full   = (rx_level == RX_FULL);
  assign rx_pop    = rxdr_rd & ~rx_empty;
  assign rx_push   = rx_valid_i & ~rx_flush & (~rx_full | rx_pop);
  assign rx_ovr    = rx_valid_i & ~rx_flush & rx_full & ~rx_pop;
  assign rx_level8 = 8'(rx_level);
  assign rxth      = (rx_level8 >= rx_thresh);

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_frame_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_level  <= '0;
    end else if (rx_flush) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + RX_LW'(1);
        2'b01:   rx_level <= rx_level - RX_LW'(1);
        default: rx_level <= rx_level;
      endcase
    end
  end

  // TX FIFO and dispatch FSM
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_rd_ptr, tx_wr_ptr;
  logic [TX_LW-1:0] tx_level;
  logic [7:0]       tx_level8;
  logic             tx_empty, tx_full, tx_pop, tx_push, tx_ovr, tx_idle;
  tx_state_t        tx_state, tx_state_next;

  assign tx_empty  = (tx_level == '0);
  assign tx_full   = (tx_level == TX_FULL);
  assign tx_push   = txdr_wr & ~tx_full & ~tx_flush;
  assign tx_ovr    = txdr_wr & tx_full & ~tx_flush;
  assign tx_level8 = 8'(tx_level);
  assign tx_idle   = tx_empty & (tx_state == TX_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tx_state <= TX_IDLE;
    else         tx_state <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_pop        = 1'b0;
    if (cr_wr) begin
      tx_state_next = TX_IDLE;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty && !tx_flush) begin
            tx_pop        = 1'b1;
            tx_state_next = TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_done_i) tx_state_next = TX_IDLE;
        end
        default: tx_state_next = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wb_dat_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_level  <= '0;
    end else if (tx_flush) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + TX_LW'(1);
        2'b01:   tx_level <= tx_level - TX_LW'(1);
        default: tx_level <= tx_level;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_transmit_o <= 1'b0;
      tx_data_o     <= 8'h00;
    end else begin
      tx_transmit_o <= tx_pop;
      if (tx_pop) tx_data_o <= tx_mem[tx_rd_ptr];
    end
  end

  // Threshold 0 would make RXTH permanently true, so it is stored as 1.
  always_comb begin
    th_sat = wb_dat_i[15:8];
    if (wb_dat_i[15:8] == 8'h00)           th_sat = 8'h01;
    else if (wb_dat_i[15:8] > RX_DEPTH_B)  th_sat = RX_DEPTH_B;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cr_acc_incr_o  <= 16'h0000;
      cr_ds_o        <= 1'b0;
      cr_s_o         <= 1'b0;
      cr_p_o         <= 2'b00;
      ier            <= 3'b000;
      rx_thresh      <= 8'h01;
      frontend_rst_o <= 1'b1;
    end else begin
      frontend_rst_o <= cr_wr;
      if (cr_wr) begin
        cr_acc_incr_o <= wb_dat_i[31:16];
        cr_ds_o       <= wb_dat_i[3];
        cr_s_o        <= wb_dat_i[2];
        cr_p_o        <= wb_dat_i[1:0];
      end
      if (ier_wr) ier       <= wb_dat_i[2:0];
      if (fcr_wr) rx_thresh <= th_sat;
    end
  end

  // A flag raised in the same cycle as the clearing SR read survives it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxoe <= 1'b0;
      fe   <= 1'b0;
      pe   <= 1'b0;
      txoe <= 1'b0;
    end else begin
      rxoe <= (rxoe & ~sr_rd) | rx_ovr;
      fe   <= (fe & ~sr_rd) | (rx_valid_i & rx_frame_err_i);
      pe   <= (pe & ~sr_rd) | (rx_valid_i & rx_parity_err_i);
      txoe <= (txoe & ~sr_rd) | tx_ovr;
    end
  end

  always_comb begin
    rdata = 32'h0000_0000;
    case (idx)
      A_SR:   rdata[7:0]  = {txoe, rxth, tx_idle, pe, fe, rxoe, ~tx_full, ~rx_empty};
      A_CR:   rdata       = {cr_acc_incr_o, 12'h000, cr_ds_o, cr_s_o, cr_p_o};
      A_RXDR: rdata[7:0]  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
      A_IER:  rdata[2:0]  = ier;
      A_FCR:  rdata[23:0] = {tx_level8, rx_thresh, rx_level8};
      default: rdata = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'h0000_0000;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd ? rdata : 32'h0000_0000;
      irq_o    <= (ier[0] & rxth) | (ier[1] & tx_idle) | (ier[2] & (rxoe | fe | pe | txoe));
    end
  end

endmodule

// File: tb/tb_ecap5_dwbuart_fifo.sv
// Directed bench for ecap5_dwbuart_fifo: bus protocol, CR/frontend reset, TX dispatch,
// RX overrun, threshold interrupt, sticky flag clearing and TX overrun.
module tb_ecap5_dwbuart_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr = '0, wb_dat_w = '0, wb_dat_r;
  logic        wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0;
  logic [3:0]  wb_sel = 4'hf;
  logic        wb_ack, wb_stall;
  logic [7:0]  rx_frame = '0;
  logic        rx_valid = 1'b0, rx_perr = 1'b0, rx_ferr = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_transmit;
  logic        tx_done = 1'b0;
  logic [15:0] acc_incr;
  logic        cr_ds, cr_s;
  logic [1:0]  cr_p;
  logic        fe_rst, irq;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q;
  logic        a;

  always #5 clk = ~clk;

  ecap5_dwbuart_fifo dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r), .wb_we_i(wb_we),
    .wb_sel_i(wb_sel), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_ack_o(wb_ack),
    .wb_stall_o(wb_stall),
    .rx_frame_i(rx_frame), .rx_valid_i(rx_valid), .rx_parity_err_i(rx_perr),
    .rx_frame_err_i(rx_ferr),
    .tx_data_o(tx_data), .tx_transmit_o(tx_transmit), .tx_done_i(tx_done),
    .cr_acc_incr_o(acc_incr), .cr_ds_o(cr_ds), .cr_s_o(cr_s), .cr_p_o(cr_p),
    .frontend_rst_o(fe_rst), .irq_o(irq)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic bus(input logic we, input logic [5:0] idx, input logic [31:0] d,
                     output logic [31:0] rq, output logic ack);
    @(negedge clk);
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = we;
    wb_adr = {24'h0, idx, 2'b00}; wb_dat_w = d;
    @(posedge clk); #1;
    ack = wb_ack; rq = wb_dat_r;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1'b1; rx_frame = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_vec++; if (fe_rst !== 1'b1) begin n_err++; $display("FAIL rst_fe_rst: got %b want 1", fe_rst); end
    n_vec++; if ({wb_ack, tx_transmit, irq} !== 3'b000) begin n_err++; $display("FAIL rst_outputs: got %b want 000", {wb_ack, tx_transmit, irq}); end
    n_vec++; if ({wb_dat_r, tx_data} !== 40'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", {wb_dat_r, tx_data}); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_vec++; if (fe_rst !== 1'b1) begin n_err++; $display("FAIL rst_fe_hold: got %b want 1", fe_rst); end
    @(posedge clk); #1;
    n_vec++; if (fe_rst !== 1'b0) begin n_err++; $display("FAIL rst_fe_release: got %b want 0", fe_rst); end
    bus(1'b0, 6'd0, 32'h0, q, a);
    n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL rst_sr_ack: got %b want 1", a); end
    n_vec++; if (q !== 32'h22) begin n_err++; $display("FAIL rst_sr: got %h want 00000022", q); end
    bus(1'b0, 6'd5, 32'h0, q, a);
    n_vec++; if (q !== 32'h100) begin n_err++; $display("FAIL rst_fcr: got %h want 00000100", q); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq); end
  endtask

  task automatic test_unmapped;
    bus(1'b1, 6'd9, 32'hffff_ffff, q, a);
    n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL unmapped_wr_ack: got %b want 1", a); end
    bus(1'b0, 6'd9, 32'h0, q, a);
    n_vec++; if ({a, q} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL unmapped_rd: got %b/%h want 1/00000000", a, q); end
    @(posedge clk); #1;
    n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL ack_single: got %b want 0", wb_ack); end
  endtask

  task automatic test_cr;
    bus(1'b1, 6'd1, 32'h0020_0005, q, a);
    n_vec++; if ({a, fe_rst} !== 2'b11) begin n_err++; $display("FAIL cr_ack_fe: got %b want 11", {a, fe_rst}); end
    n_vec++; if ({acc_incr, cr_ds, cr_s, cr_p} !== {16'h0020, 1'b0, 1'b1, 2'b01}) begin
      n_err++; $display("FAIL cr_fields: got %h %b %b %b want 0020 0 1 01", acc_incr, cr_ds, cr_s, cr_p); end
    @(posedge clk); #1;
    n_vec++; if (fe_rst !== 1'b0) begin n_err++; $display("FAIL cr_fe_pulse: got %b want 0", fe_rst); end
    bus(1'b0, 6'd1, 32'h0, q, a);
    n_vec++; if (q !== 32'h0020_0005) begin n_err++; $display("FAIL cr_read: got %h want 00200005", q); end
  endtask

  task automatic test_back_to_back_tx;
    @(negedge clk);
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = {24'h0, 6'd3, 2'b00}; wb_dat_w = 32'h41;
    @(posedge clk); #1;
    n_vec++; if ({wb_ack, tx_transmit} !== 2'b10) begin n_err++; $display("FAIL tx_first_edge: got %b want 10", {wb_ack, tx_transmit}); end
    @(negedge clk); wb_dat_w = 32'h42;
    @(posedge clk); #1;
    n_vec++; if ({wb_ack, tx_transmit, tx_data} !== {2'b11, 8'h41}) begin
      n_err++; $display("FAIL tx_pulse1: got %b %b %h want 1 1 41", wb_ack, tx_transmit, tx_data); end
    @(negedge clk); wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    n_vec++; if ({wb_ack, tx_transmit, tx_data} !== {2'b00, 8'h41}) begin
      n_err++; $display("FAIL tx_pulse1_end: got %b %b %h want 0 0 41", wb_ack, tx_transmit, tx_data); end
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    @(posedge clk); #1;
    n_vec++; if ({tx_transmit, tx_data} !== {1'b1, 8'h42}) begin
      n_err++; $display("FAIL tx_pulse2: got %b %h want 1 42", tx_transmit, tx_data); end
    bus(1'b0, 6'd0, 32'h0, q, a);
    n_vec++; if (q !== 32'h02) begin n_err++; $display("FAIL tx_busy_sr: got %h want 00000002", q); end
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    bus(1'b0, 6'd0, 32'h0, q, a);
    n_vec++; if (q !== 32'h22) begin n_err++; $display("FAIL tx_idle_sr: got %h want 00000022", q); end
  endtask

  task automatic test_rx_overrun;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_frame = 8'(i);
    end
    @(negedge clk); rx_valid = 1'b0;
    bus(1'b0, 6'd5, 32'h0, q, a);
    n_vec++; if (q !== 32'h110) begin n_err++; $display("FAIL rx_full_fcr: got %h want 00000110", q); end
    bus(1'b0, 6'd0, 32'h0, q, a);
    n_vec++; if (q !== 32'h67) begin n_err++; $display("FAIL rx_ovr_sr: got %h want 00000067", q); end
    for (int i = 0; i < 16; i++) begin
      bus(1'b0, 6'd2, 32'h0, q, a);
      n_vec++; if (q !== 32'(i)) begin n_err++; $display("FAIL rx_order[%0d]: got %h want %h", i, q, 32'(i)); end
    end
    bus(1'b0, 6'd2, 32'h0, q, a);
    n_vec++; if (q !== 32'h0) begin n_err++; $display("FAIL rx_empty_read: got %h want 00000000", q); end
    bus(1'b0, 6'd0, 32'h0, q, a);
    n_vec++; if (q !== 32'h22) begin n_err++; $display("FAIL rx_drained_sr: got %h want 00000022", q); end
  endtask

  task automatic test_threshold_irq;
    bus(1'b1, 6'd4, 32'h1, q, a);
    bus(1'b1, 6'd5, 32'h0400, q, a);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_frame = 8'hA0 + 8'(i);
    end
    @(negedge clk); rx_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL th_below: got %b want 0", irq); end
    rx_push(8'hA3);
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL th_early: got %b want 0", irq); end
    @(posedge clk); #1;
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL th_irq: got %b want 1", irq); end
    bus(1'b0, 6'd2, 32'h0, q, a);
    n_vec++; if (q !== 32'hA0) begin n_err++; $display("FAIL th_rxdr: got %h want 000000a0", q); end
    @(posedge clk); #1;
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL th_irq_clear: got %b want 0", irq); end
    bus(1'b1, 6'd4, 32'h0, q, a);
    bus(1'b1, 6'd5, 32'h0401, q, a);
    bus(1'b0, 6'd5, 32'h0, q, a);
    n_vec++; if (q !== 32'h400) begin n_err++; $display("FAIL fcr_flush: got %h want 00000400", q); end
    bus(1'b1, 6'd5, 32'h0000, q, a);
    bus(1'b0, 6'd5, 32'h0, q, a);
    n_vec++; if (q !== 32'h100) begin n_err++; $display("FAIL th_zero: got %h want 00000100", q); end
    bus(1'b1, 6'd5, 32'hC800, q, a);
    bus(1'b0, 6'd5, 32'h0, q, a);
    n_vec++; if (q !== 32'h1000) begin n_err++; $display("FAIL th_sat: got %h want 00001000", q); end
  endtask

  task automatic test_sticky_clear;
    @(negedge clk);
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = 32'h0;
    rx_valid = 1'b1; rx_perr = 1'b1; rx_frame = 8'h55;
    @(posedge clk); #1;
    n_vec++; if (wb_dat_r !== 32'h22) begin n_err++; $display("FAIL pe_same_cycle: got %h want 00000022", wb_dat_r); end
    wb_stb = 1'b0; wb_cyc = 1'b0; rx_valid = 1'b0; rx_perr = 1'b0;
    bus(1'b0, 6'd0, 32'h0, q, a);
    n_vec++; if (q !== 32'h33) begin n_err++; $display("FAIL pe_kept: got %h want 00000033", q); end
    bus(1'b0, 6'd0, 32'h0, q, a);
    n_vec++; if (q !== 32'h23) begin n_err++; $display("FAIL pe_cleared: got %h want 00000023", q); end
  endtask

  task automatic test_tx_overrun;
    bus(1'b1, 6'd4, 32'h4, q, a);
    for (int i = 0; i < 18; i++) bus(1'b1, 6'd3, 32'h10 + 32'(i), q, a);
    @(posedge clk); #1;
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL txoe_irq: got %b want 1", irq); end
    n_vec++; if (tx_data !== 8'h10) begin n_err++; $display("FAIL txoe_data: got %h want 10", tx_data); end
    bus(1'b0, 6'd5, 32'h0, q, a);
    n_vec++; if (q !== 32'h0010_1001) begin n_err++; $display("FAIL txoe_fcr: got %h want 00101001", q); end
    bus(1'b0, 6'd0, 32'h0, q, a);
    n_vec++; if (q !== 32'h81) begin n_err++; $display("FAIL txoe_sr: got %h want 00000081", q); end
    @(posedge clk); #1;
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL txoe_irq_clear: got %b want 0", irq); end
    bus(1'b1, 6'd1, 32'h0020_0005, q, a);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++; if ({tx_transmit, tx_data} !== {1'b0, 8'h10}) begin
      n_err++; $display("FAIL cr_tx_quiet: got %b %h want 0 10", tx_transmit, tx_data); end
    bus(1'b0, 6'd0, 32'h0, q, a);
    n_vec++; if (q !== 32'h22) begin n_err++; $display("FAIL cr_flush_sr: got %h want 00000022", q); end
    bus(1'b0, 6'd4, 32'h0, q, a);
    n_vec++; if (q !== 32'h4) begin n_err++; $display("FAIL cr_keeps_ier: got %h want 00000004", q); end
  endtask

  initial begin
    test_reset;
    test_unmapped;
    test_cr;
    test_back_to_back_tx;
    test_rx_overrun;
    test_threshold_irq;
    test_sticky_clear;
    test_tx_overrun;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ecap5_dwbuart_fifo.md
Name: ecap5_dwbuart_fifo

Overview:
Next-generation register and buffering core for the Wishbone UART. It replaces the single-entry RXDR/TXDR registers with parametrised RX and TX FIFOs, an autonomous TX dispatch FSM, sticky error flags, an RX level threshold and a level interrupt. It sits between the Wishbone bus and the existing rx_frontend and tx_frontend, which connect through the frontend ports below.

Parameters:
RX_DEPTH, 16, RX FIFO entries; power of 2, range 2..128
TX_DEPTH, 16, TX FIFO entries; power of 2, range 2..128

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_ni  in  1  reset, asynchronous, active-low
wb_adr_i  in  32  byte address; only [7:2] is decoded
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, registered
wb_we_i  in  1  write enable
wb_sel_i  in  4  byte select; ignored, all accesses are full-word
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_ack_o  out  1  acknowledge
wb_stall_o  out  1  stall; tied to 0
rx_frame_i  in  8  received data from rx_frontend
rx_valid_i  in  1  one-cycle pulse: frame valid
rx_parity_err_i  in  1  parity error; qualified by rx_valid_i
rx_frame_err_i  in  1  framing error; qualified by rx_valid_i
tx_data_o  out  8  byte to transmit
tx_transmit_o  out  1  one-cycle start pulse to tx_frontend
tx_done_i  in  1  one-cycle pulse: frame fully sent
cr_acc_incr_o  out  16  baud accumulator increment
cr_ds_o, cr_s_o  out  1 each  data-size and stop-bit config
cr_p_o  out  2  parity config
frontend_rst_o  out  1  active-high reset for both frontends
irq_o  out  1  level interrupt, registered

Behaviour:
- Reset (rst_ni low, asynchronous): all registers 0, both FIFOs empty, TX FSM in IDLE, RX threshold 1. Outputs: wb_ack_o=0, wb_dat_o=0, tx_transmit_o=0, tx_data_o=0, irq_o=0, frontend_rst_o=1. frontend_rst_o stays 1 until the first clock edge after rst_ni rises.
- Bus request: a request is stb&cyc sampled at an edge. wb_ack_o=1 exactly one cycle later, and wb_dat_o is valid in that cycle. Back-to-back requests get back-to-back acks; the bus never stalls. Any access to an unmapped address acks; reads return 0 and writes are ignored.
- Register map (word index):
  - 0 SR (read-only):
    - [0] RXNE: RX FIFO not empty
    - [1] TXNF: TX FIFO not full
    - [2] RXOE: sticky RX overrun
    - [3] FE: sticky framing error
    - [4] PE: sticky parity error
    - [5] TXIDLE: TX FIFO empty and FSM in IDLE
    - [6] RXTH: RX level >= threshold
    - [7] TXOE: sticky TX overrun
  - 1 CR (read/write): [31:16] acc_incr, [3] ds, [2] s, [1:0] p.
  - 2 RXDR (read pops): [7:0] head of RX FIFO.
  - 3 TXDR (write pushes): [7:0].
  - 4 IER (read/write):
    - [0] enable RXTH interrupt
    - [1] enable TXIDLE interrupt
    - [2] enable error interrupt (RXOE|FE|PE|TXOE)
  - 5 FCR:
    - write: [0] flush RX, [1] flush TX, [15:8] RX threshold; a written value of 0 is stored as 1, and values above RX_DEPTH saturate to RX_DEPTH.
    - read: [7:0] RX level, [15:8] threshold, [23:16] TX level.
- Sticky flags: a read of SR clears RXOE, FE, PE and TXOE. A flag set in the same cycle as the clearing read remains set, and the returned value is the pre-clear value.
- RX path:
  - rx_valid_i pushes rx_frame_i, and ORs rx_parity_err_i/rx_frame_err_i into PE/FE.
  - A push into a full FIFO is dropped and sets RXOE, unless a pop happens in the same cycle; in that case both succeed and there is no overrun.
  - A read of RXDR returns the head and pops it. A read of an empty FIFO returns 0 with no side effect.
- TX path:
  - A write to TXDR pushes the data. A write to a full FIFO is discarded and sets TXOE.
  - FSM IDLE: if the FIFO is non-empty, pop the head into tx_data_o, pulse tx_transmit_o for one cycle and go to BUSY.
  - FSM BUSY: on tx_done_i, go to IDLE.
  - With the FSM idle and the FIFO empty, a write sampled at edge N gives tx_transmit_o=1 in the cycle after edge N+1.
  - The next byte's transmit pulse follows one cycle after the IDLE state is re-entered.
  - tx_data_o holds its value until the next pop.
- CR write: the registers update, frontend_rst_o pulses for exactly one cycle (the ack cycle), both FIFOs flush, and the TX FSM is forced to IDLE. A tx_done_i in that cycle is ignored. Sticky flags and IER are unaffected.
- Flush: the FIFO pointers and level go to 0 on the edge after the request. A push in the same cycle as a flush is discarded and sets no overrun flag.
- irq_o, registered: (IER[0]&RXTH) | (IER[1]&TXIDLE) | (IER[2]&(RXOE|FE|PE|TXOE)).
- Levels are log2(DEPTH)+1 bits wide, zero-extended into their 8-bit fields. The FIFO pointers wrap modulo DEPTH.

Test Plan:
- Reset, then read SR -> 0x22 (TXNF=1, TXIDLE=1); read FCR -> 0x000100; irq_o=0; frontend_rst_o=1 until the first edge after rst_ni rises.
- Write CR=0x00200005 -> ack next cycle; frontend_rst_o high for 1 cycle; cr_acc_incr_o=0x0020, cr_s_o=1, cr_p_o=1; read CR -> 0x00200005.
- Write TXDR 0x41, 0x42 back-to-back -> tx_transmit_o pulses with tx_data_o=0x41; after tx_done_i, it pulses again with 0x42; after the second tx_done_i, TXIDLE=1.
- 17 rx_valid_i pulses (data 0..16) with RX_DEPTH=16 -> FCR[7:0]=16; SR RXOE=1; RXDR reads return 0..15 in order; the 17th read returns 0 and RXNE=0.
- Set IER=0x1 and FCR threshold=4, push 3 frames -> irq_o=0; push a 4th -> irq_o=1 one cycle later; one RXDR read -> irq_o=0.
- rx_valid_i with rx_parity_err_i=1 in the same cycle as an SR read -> returned PE=0, PE stays 1; the next SR read returns PE=1 and then clears it.
